idli_fetch_m: RTL
=================

Name: idli_fetch_m

Overview:
SQI instruction fetch sequencer directly upstream of the instruction decoder. Issues quad-mode read transactions to the external SQI memory and streams 16b instructions to the decoder as four consecutive 4b nibbles, MSB nibble first, with a valid strobe. Tracks the fetch PC, handles redirects and backend back-pressure at instruction boundaries, and restarts the memory transaction when required.

Parameters:
RESET_PC, 16'h0000, word address fetched first after reset.
DUMMY_CYCLES, 2, SQI dummy nibble cycles between the last address nibble and the first data nibble (1..7).
READ_CMD, 8'hEB, SQI quad read opcode, sent as 2 nibbles.

Ports:
i_dcd_gck  in  1  clock.
i_dcd_rst_n  in  1  reset, asynchronous, active-low.
o_sqi_cs_n  out  1  memory chip select, active-low.
o_sqi_sio  out  4  nibble driven to memory.
o_sqi_oe  out  1  SIO output enable; 1 during command and address phases.
i_sqi_sio  in  4  nibble returned by memory.
i_ftch_rdy  in  1  backend can accept a new instruction; sampled only at instruction boundaries.
i_ftch_redir_vld  in  1  redirect request, single-cycle pulse.
i_ftch_redir_pc  in  16  redirect target word address.
o_dcd_enc  out  4  instruction nibble to the decoder.
o_dcd_enc_vld  out  1  o_dcd_enc valid.
o_ftch_pc  out  16  word address of the instruction currently presented.

Behaviour:
- Reset: cs_n=1, oe=0, sio=0, enc=0, enc_vld=0, pc=RESET_PC, state=IDLE, no pending redirect.
- States: IDLE -> CMD (2 cycles) -> ADDR (6 cycles) -> DUMMY (DUMMY_CYCLES) -> DATA (repeating 4-cycle instruction slots) -> IDLE.
- IDLE: cs_n=1 for at least 1 cycle. Go to CMD when i_ftch_rdy=1.
- CMD: cs_n=0, oe=1, sio = READ_CMD[7:4], then [3:0].
- ADDR: 24b byte address {7'b0, pc, 1'b0}, MSB nibble first.
- DUMMY: oe=0, cs_n=0.
- DATA: oe=0, cs_n=0. A 2b nibble counter selects the nibble within the slot.
- Output registration: o_dcd_enc and o_dcd_enc_vld are registered from i_sqi_sio and the data-phase flag, giving 1 cycle latency. enc_vld is high for exactly 4 consecutive cycles per instruction, with no gaps inside an instruction.
- Streaming: back-to-back instructions follow with no bubble while in DATA.
- o_ftch_pc is updated on the cycle the first nibble of a slot is presented and stays stable for all 4 nibbles. The internal fetch pc increments by 1 after each nibble 3.
- Boundary (end of nibble 3), evaluated in priority order:
  - (a) Pending redirect: pc=redir_pc, clear pending, go to IDLE.
  - (b) Internal pc wrapped from 16'hFFFF to 0: go to IDLE. The transaction restarts at 0.
  - (c) i_ftch_rdy=0: go to IDLE, holding pc.
  - (d) Otherwise continue in DATA.
- Redirects:
  - i_ftch_redir_vld in any state sets pending and latches redir_pc. A later redirect overwrites an earlier one.
  - In IDLE, CMD, ADDR or DUMMY, a redirect aborts immediately: cs_n=1, state goes to IDLE, and no enc_vld is produced from the aborted transaction.
  - In DATA, the current instruction always completes all 4 nibbles, because the decoder must never see a partial instruction.
- IDLE re-entry: the transaction restarts once i_ftch_rdy=1 after the mandatory cs_n-high cycle.
- Reset asserted mid-transaction forces all reset values immediately (asynchronous); any partial instruction is dropped.

Decomposition:
- idli_pkg gains:
  - fetch state enum fetch_state_t (IDLE, CMD, ADDR, DUMMY, DATA);
  - a word-address typedef addr_t (16b);
  - SQI_CMD_NIBBLES=2 and SQI_ADDR_NIBBLES=6.
- No sub-module. The module is a single FSM plus one shared phase counter (3b) and the pc register.

Test Plan:
- Reset then rdy=1, DUMMY_CYCLES=2: cs_n low from cycle 1. sio sequence E, B, 0, 0, 0, 0, 0, 0, then 2 dummy cycles. Memory returns 1,2,3,4: enc=1,2,3,4 with vld high for 4 cycles, 1 cycle after each nibble, and o_ftch_pc=0.
- Stream of 3 instructions, rdy held high: 12 consecutive vld cycles, o_ftch_pc steps 0,1,2, cs_n stays low throughout.
- Redirect to 16'h0100 pulsed on nibble 1 of instruction at pc 5: nibbles 2-3 still delivered. Then cs_n=1 for 1 cycle and a new transaction starts with address nibbles 0,0,0,2,0,0; next o_ftch_pc=16'h0100.
- Redirect to 16'h0040 pulsed during ADDR phase: cs_n high next cycle, no vld pulses, restart with address 0x000080.
- rdy=0 at boundary after pc 16'hFFFF, held 3 cycles: cs_n high for 3 cycles. rdy=1 then restarts at pc 0 with address 000000.
- Reset asserted on nibble 2 of an instruction: cs_n=1, vld=0 in the same cycle. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core front end.
// Holds fetch FSM encoding, word-address type and SQI framing sizes.
package idli_pkg;

    typedef logic [15:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA
    } fetch_state_t;

    localparam int SQI_CMD_NIBBLES  = 2;
    localparam int SQI_ADDR_NIBBLES = 6;

    // Nibble idx (0 = MSB) of the 24b byte address of word address pc.
    function automatic logic [3:0] addr_nibble(
        input addr_t      pc,
        input logic [2:0] idx
    );
        logic [23:0] byte_addr;
        logic [3:0]  nib;
        byte_addr = {7'b0, pc, 1'b0};
        case (idx)
            3'd0:    nib = byte_addr[23:20];
            3'd1:    nib = byte_addr[19:16];
            3'd2:    nib = byte_addr[15:12];
            3'd3:    nib = byte_addr[11:8];
            3'd4:    nib = byte_addr[7:4];
            3'd5:    nib = byte_addr[3:0];
            default: nib = '0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/idli_fetch_m.sv
// SQI instruction fetch sequencer: quad read transactions in,
// 16b instructions out to the decoder as 4 nibbles, MSB first.
module idli_fetch_m
    import idli_pkg::*;
#(
    parameter addr_t      RESET_PC     = 16'h0000,
    parameter int         DUMMY_CYCLES = 2,
    parameter logic [7:0] READ_CMD     = 8'hEB
) (
    input  logic        i_dcd_gck,
    input  logic        i_dcd_rst_n,
    output logic        o_sqi_cs_n,
    output logic [3:0]  o_sqi_sio,
    output logic        o_sqi_oe,
    input  logic [3:0]  i_sqi_sio,
    input  logic        i_ftch_rdy,
    input  logic        i_ftch_redir_vld,
    input  logic [15:0] i_ftch_redir_pc,
    output logic [3:0]  o_dcd_enc,
    output logic        o_dcd_enc_vld,
    output logic [15:0] o_ftch_pc
);

    localparam logic [2:0] CMD_LAST   = 3'(SQI_CMD_NIBBLES - 1);
    localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

    fetch_state_t state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    addr_t        pc_q, pc_d;
    addr_t        vis_pc_q, vis_pc_d;
    logic         redir_pend_q, redir_pend_d;
    addr_t        redir_pc_q, redir_pc_d;
    logic [3:0]   enc_q, enc_d;
    logic         enc_vld_q, enc_vld_d;

    addr_t        tgt_pc;
    logic         in_data;
    logic         slot_end;

    assign in_data  = (state_q == DATA);
    assign slot_end = in_data && (cnt_q[1:0] == 2'd3);
    assign tgt_pc   = i_ftch_redir_vld ? i_ftch_redir_pc : redir_pc_q;

    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pc_q         <= RESET_PC;
            vis_pc_q     <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
            enc_q        <= '0;
            enc_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            vis_pc_q     <= vis_pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            enc_q        <= enc_d;
            enc_vld_q    <= enc_vld_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q | i_ftch_redir_vld;
        redir_pc_d   = tgt_pc;

        unique case (state_q)
            IDLE: begin
                if (i_ftch_rdy) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
            end
            CMD: begin
                if (cnt_q == CMD_LAST) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    state_d = DUMMY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DATA: begin
                cnt_d = {1'b0, cnt_q[1:0] + 2'd1};
                if (slot_end) begin
                    pc_d = pc_q + 16'd1;
                    if (redir_pend_d) begin
                        pc_d         = tgt_pc;
                        redir_pend_d = 1'b0;
                        state_d      = IDLE;
                    end else if (pc_q == 16'hFFFF) begin
                        state_d = IDLE;
                    end else if (!i_ftch_rdy) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outside DATA no nibble is in flight, so a redirect takes effect now.
        if (i_ftch_redir_vld && !in_data) begin
            pc_d         = i_ftch_redir_pc;
            redir_pend_d = 1'b0;
            if (state_q != IDLE) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        enc_d     = in_data ? i_sqi_sio : 4'h0;
        enc_vld_d = in_data;
        vis_pc_d  = vis_pc_q;
        if (in_data && (cnt_q[1:0] == 2'd0)) begin
            vis_pc_d = pc_q;
        end
    end

    always_comb begin
        o_sqi_cs_n = 1'b1;
        o_sqi_oe   = 1'b0;
        o_sqi_sio  = 4'h0;
        unique case (state_q)
            CMD: begin
                o_sqi_cs_n = 1'b0;
                o_sqi_oe   = 1'b1;
                o_sqi_sio  = cnt_q[0] ? READ_CMD[3:0] : READ_CMD[7:4];
            end
            ADDR: begin
                o_sqi_cs_n = 1'b0;
                o_sqi_oe   = 1'b1;
                o_sqi_sio  = addr_nibble(pc_q, cnt_q);
            end
            DUMMY, DATA: begin
                o_sqi_cs_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_dcd_enc     = enc_q;
    assign o_dcd_enc_vld = enc_vld_q;
    assign o_ftch_pc     = vis_pc_q;

endmodule
